// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: constants shared by the GPIO bank and its synchroniser.
//   IO_DW        width of the CPU io data bus
//   GPIO_*       3-bit register indices within one bank
package gpio_bank_pkg;

    localparam int IO_DW = 16;

    localparam logic [2:0] GPIO_DATA  = 3'd0;  // rd: synced pins, wr: load out
    localparam logic [2:0] GPIO_DIR   = 3'd1;  // direction, 1 = drive pad
    localparam logic [2:0] GPIO_SET   = 3'd2;  // rd: out, wr: out |= data
    localparam logic [2:0] GPIO_CLR   = 3'd3;  // rd: out, wr: out &= ~data
    localparam logic [2:0] GPIO_RISE  = 3'd4;  // rising-edge capture enable
    localparam logic [2:0] GPIO_FALL  = 3'd5;  // falling-edge capture enable
    localparam logic [2:0] GPIO_EVENT = 3'd6;  // sticky events, write-1-to-clear
    localparam logic [2:0] GPIO_IRQEN = 3'd7;  // per-pin interrupt enable

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-wide, SYNC_STAGES-deep input synchroniser with a
// previous-value register for edge detection.
//   clk, resetq   clock, synchronous active-low reset
//   pin_i         raw asynchronous pad inputs
//   s_o           synchronised pin value
//   rise_o        s went 0->1 since last cycle
//   fall_o        s went 1->0 since last cycle
module gpio_sync
    import gpio_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Stage 0 samples the pad; the last stage is the synchronised value.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev and s both clear on reset, so the first cycle after release
    // can never report an edge.
    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = s_o & ~prev_q;
    assign fall_o = ~s_o & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank on the CPU io bus.
//   clk, resetq        clock, synchronous active-low reset
//   sel                bank select (one-hot io_address bit)
//   reg_addr           register index (see gpio_bank_pkg)
//   wr, wr_data        write strobe and data (bits >= WIDTH ignored)
//   rd_data            combinational read data, 0 when not selected
//   pin_in             raw pad inputs
//   pin_out, pin_oe    output and direction registers for the pad cells
//   irq                registered interrupt request
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             sel,
    input  logic [2:0]       reg_addr,
    input  logic             wr,
    input  logic [IO_DW-1:0] wr_data,
    output logic [IO_DW-1:0] rd_data,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    logic [WIDTH-1:0] s, rise, fall;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetq (resetq),
        .pin_i  (pin_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    logic [WIDTH-1:0] out_q,     out_d;
    logic [WIDTH-1:0] dir_q,     dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] event_q,   event_d;
    logic [WIDTH-1:0] irq_en_q,  irq_en_d;
    logic             irq_q,     irq_d;

    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic             wr_data_unused;

    assign we             = sel & wr;
    assign wdata          = wr_data[WIDTH-1:0];
    assign wr_data_unused = ^wr_data;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        clr       = '0;
        if (we) begin
            case (reg_addr)
                GPIO_DATA:  out_d     = wdata;
                GPIO_DIR:   dir_d     = wdata;
                GPIO_SET:   out_d     = out_q | wdata;
                GPIO_CLR:   out_d     = out_q & ~wdata;
                GPIO_RISE:  rise_en_d = wdata;
                GPIO_FALL:  fall_en_d = wdata;
                GPIO_EVENT: clr       = wdata;
                GPIO_IRQEN: irq_en_d  = wdata;
                default:    ;
            endcase
        end
        // The clear is applied before the new edges are ORed in, so an edge
        // arriving in the same cycle as its clear is kept.
        event_d = (event_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d   = |(event_q & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            out_q     <= OUT_RESET;
            dir_q     <= DIR_RESET;
            rise_en_q <= '0;
            fall_en_q <= '0;
            event_q   <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            event_q   <= event_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (reg_addr)
                GPIO_DATA:  rd_data[WIDTH-1:0] = s;
                GPIO_DIR:   rd_data[WIDTH-1:0] = dir_q;
                GPIO_SET:   rd_data[WIDTH-1:0] = out_q;
                GPIO_CLR:   rd_data[WIDTH-1:0] = out_q;
                GPIO_RISE:  rd_data[WIDTH-1:0] = rise_en_q;
                GPIO_FALL:  rd_data[WIDTH-1:0] = fall_en_q;
                GPIO_EVENT: rd_data[WIDTH-1:0] = event_q;
                GPIO_IRQEN: rd_data[WIDTH-1:0] = irq_en_q;
                default:    ;
            endcase
        end
    end

    assign pin_out = out_q;
    assign pin_oe  = dir_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed scenarios plus randomized traffic on an 8-pin bank,
// checked every cycle against a register-level model; a 4-pin bank checks
// masking of unused data bits.
module tb_gpio_bank;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        sel = 1'b0;
    logic [2:0]  reg_addr = '0;
    logic        wr = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic [7:0]  pin_in = '0;
    logic [7:0]  pin_out, pin_oe;
    logic        irq;

    logic        sel4 = 1'b0;
    logic [2:0]  reg_addr4 = '0;
    logic        wr4 = 1'b0;
    logic [15:0] wr_data4 = '0;
    logic [15:0] rd_data4;
    logic [3:0]  pin_in4 = '0;
    logic [3:0]  pin_out4, pin_oe4;
    logic        irq4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(SS)) u_dut (
        .clk(clk), .resetq(resetq), .sel(sel), .reg_addr(reg_addr), .wr(wr),
        .wr_data(wr_data), .rd_data(rd_data), .pin_in(pin_in),
        .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
    );

    gpio_bank #(.WIDTH(4), .SYNC_STAGES(SS)) u_dut4 (
        .clk(clk), .resetq(resetq), .sel(sel4), .reg_addr(reg_addr4), .wr(wr4),
        .wr_data(wr_data4), .rd_data(rd_data4), .pin_in(pin_in4),
        .pin_out(pin_out4), .pin_oe(pin_oe4), .irq(irq4)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Registers as plain variables; the pin history holds what was on the
    // pads at each past clock edge (index 0 = most recent).
    logic [7:0] m_out, m_dir, m_ren, m_fen, m_ev, m_ien;
    logic       m_irq;
    logic [7:0] hist [0:SS];
    bit         m_valid = 0;

    function automatic logic [15:0] model_rd();
        logic [7:0] v;
        if (!sel) return 16'h0000;
        case (reg_addr)
            3'd0: v = hist[SS-1];
            3'd1: v = m_dir;
            3'd2, 3'd3: v = m_out;
            3'd4: v = m_ren;
            3'd5: v = m_fen;
            3'd6: v = m_ev;
            default: v = m_ien;
        endcase
        return {8'h00, v};
    endfunction

    task automatic model_edge();
        logic [7:0] s, p, rise, fall, d, clr, ev_new;
        logic       irq_new;
        if (!resetq) begin
            m_out = 8'h00; m_dir = 8'h00; m_ren = 8'h00; m_fen = 8'h00;
            m_ev = 8'h00; m_ien = 8'h00; m_irq = 1'b0;
            for (int i = 0; i <= SS; i++) hist[i] = 8'h00;
            m_valid = 1;
            return;
        end
        s    = hist[SS-1];
        p    = hist[SS];
        rise = s & ~p;
        fall = ~s & p;
        d    = wr_data[7:0];
        clr  = (sel && wr && reg_addr == 3'd6) ? d : 8'h00;
        ev_new  = (m_ev & ~clr) | (rise & m_ren) | (fall & m_fen);
        irq_new = (m_ev & m_ien) != 8'h00;
        if (sel && wr) begin
            case (reg_addr)
                3'd0: m_out = d;
                3'd1: m_dir = d;
                3'd2: m_out = m_out | d;
                3'd3: m_out = m_out & ~d;
                3'd4: m_ren = d;
                3'd5: m_fen = d;
                3'd7: m_ien = d;
                default: ;
            endcase
        end
        m_ev  = ev_new;
        m_irq = irq_new;
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pin_in;
    endtask

    // Compare process: model steps on each edge, DUT sampled 1 time unit later.
    always @(posedge clk) begin
        model_edge();
        #1;
        if (m_valid) begin
            chk("cyc_pin_out", {8'h00, pin_out}, {8'h00, m_out});
            chk("cyc_pin_oe",  {8'h00, pin_oe},  {8'h00, m_dir});
            chk("cyc_irq",     {15'h0, irq},     {15'h0, m_irq});
            chk("cyc_rd_data", rd_data,          model_rd());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; reg_addr = a; wr_data = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [15:0] v);
        sel = 1'b1; wr = 1'b0; reg_addr = a;
        #1 v = rd_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] v;

        // Reset with a write held active: nothing may stick.
        sel = 1'b1; wr = 1'b1; reg_addr = 3'd0; wr_data = 16'h00FF;
        repeat (3) @(negedge clk);
        wr = 1'b0;
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), v);
            chk($sformatf("reset_rd%0d", a), v, 16'h0000);
        end
        chk("reset_pin_out", {8'h00, pin_out}, 16'h0000);
        chk("reset_pin_oe",  {8'h00, pin_oe},  16'h0000);
        chk("reset_irq",     {15'h0, irq},     16'h0000);
        @(negedge clk);
        resetq = 1'b1;

        // Set / clear of the output register.
        do_write(3'd0, 16'h000F);
        chk("load_pin_out", {8'h00, pin_out}, 16'h000F);
        do_write(3'd2, 16'h0030);
        do_read(3'd2, v);
        chk("set_rd", v, 16'h003F);
        chk("set_pin_out", {8'h00, pin_out}, 16'h003F);
        do_write(3'd3, 16'h0005);
        do_read(3'd2, v);
        chk("clr_rd", v, 16'h003A);
        chk("clr_pin_out", {8'h00, pin_out}, 16'h003A);

        // Edge capture: pin1 starts high so it can fall later.
        pin_in = 8'h02;
        idle(4);
        do_write(3'd4, 16'h0001);
        do_write(3'd5, 16'h0002);
        do_write(3'd7, 16'h0003);
        do_read(3'd6, v);
        chk("ev_initial", v, 16'h0000);

        // Pin 0 rises before edge k: event after k+2, irq after k+3.
        @(negedge clk);
        pin_in = 8'h03; sel = 1'b1; wr = 1'b0; reg_addr = 3'd6;
        @(posedge clk); @(posedge clk); #1;
        chk("ev_k1", rd_data, 16'h0000);
        @(posedge clk); #1;
        chk("ev_k2", rd_data, 16'h0001);
        chk("irq_k2", {15'h0, irq}, 16'h0000);
        @(posedge clk); #1;
        chk("irq_k3", {15'h0, irq}, 16'h0001);

        @(negedge clk); pin_in = 8'h01;   // pin 1 falls
        idle(4);
        do_read(3'd6, v);
        chk("ev_fall", v, 16'h0003);
        @(negedge clk); pin_in = 8'h03;   // pin 1 rises, not enabled
        idle(4);
        do_read(3'd6, v);
        chk("ev_rise_off", v, 16'h0003);

        // W1C race: clear of bit 0 lands on the edge a new rise sets it.
        do_write(3'd6, 16'h0002);
        do_read(3'd6, v);
        chk("ev_pre_race", v, 16'h0001);
        @(negedge clk); pin_in = 8'h02;
        idle(4);
        pin_in = 8'h03;                   // before edge k
        @(negedge clk);                   // between k and k+1
        @(negedge clk);                   // between k+1 and k+2
        sel = 1'b1; wr = 1'b1; reg_addr = 3'd6; wr_data = 16'h0001;
        @(negedge clk);
        wr = 1'b0;
        do_read(3'd6, v);
        chk("race_ev", v, 16'h0001);
        chk("race_irq", {15'h0, irq}, 16'h0001);

        // Clear all, irq falls two edges after the write.
        do_write(3'd6, 16'h0003);
        do_read(3'd6, v);
        chk("clrall_ev", v, 16'h0000);
        chk("clrall_irq_w1", {15'h0, irq}, 16'h0001);
        @(posedge clk); #1;
        chk("clrall_irq_w2", {15'h0, irq}, 16'h0000);

        // Unselected bank: reads 0, writes ignored.
        @(negedge clk);
        sel = 1'b0; reg_addr = 3'd2; wr = 1'b0;
        #1 chk("unsel_rd", rd_data, 16'h0000);
        @(negedge clk);
        sel = 1'b0; wr = 1'b1; reg_addr = 3'd0; wr_data = 16'h00AA;
        @(negedge clk);
        wr = 1'b0;
        do_read(3'd2, v);
        chk("unsel_wr", v, 16'h003A);

        // 4-pin bank: upper data bits are dropped.
        @(negedge clk);
        sel4 = 1'b1; wr4 = 1'b1; reg_addr4 = 3'd1; wr_data4 = 16'hFFFF;
        @(negedge clk);
        wr4 = 1'b0;
        #1;
        chk("w4_rd_dir", rd_data4, 16'h000F);
        chk("w4_pin_oe", {12'h000, pin_oe4}, 16'h000F);
        sel4 = 1'b0;
        #1 chk("w4_unsel", rd_data4, 16'h0000);

        // Randomized traffic, checked by the per-cycle model compare.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            resetq   = ($urandom_range(199) != 0);
            sel      = ($urandom_range(7) != 0);
            wr       = ($urandom_range(2) == 0);
            reg_addr = 3'($urandom_range(7));
            wr_data  = 16'($urandom);
            if ($urandom_range(2) == 0)
                pin_in = pin_in ^ (8'h01 << $urandom_range(7));
        end
        @(negedge clk);
        resetq = 1'b1; wr = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised memory-mapped GPIO bank. Successor to the fixed 8-bit PMOD/HDR ports.
- Adds configurable width, an input synchroniser, atomic set/clear of outputs, per-pin rising/falling edge capture, write-1-to-clear event status and a registered interrupt output.
- Sits on the CPU io bus, selected by one one-hot io_address bit plus a 3-bit register index.
- Exposes raw pin_in/pin_out/pin_oe so the top level wraps them in SB_IO (plain input, registered output/enable).

Parameters:
- WIDTH, 8, number of pins (1..16).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- OUT_RESET, 0, reset value of the output register (WIDTH bits).
- DIR_RESET, 0, reset value of the direction register (1 = output).

Ports:
- clk  in  1  system clock.
- resetq  in  1  synchronous active-low reset.
- sel  in  1  bank selected (one-hot io_address bit).
- reg_addr  in  3  register index.
- wr  in  1  io write strobe; effective only when sel=1.
- wr_data  in  16  write data; bits >= WIDTH are ignored.
- rd_data  out  16  read data (combinational); 0 when sel=0; bits >= WIDTH are 0.
- pin_in  in  WIDTH  raw pad inputs (asynchronous).
- pin_out  out  WIDTH  output register.
- pin_oe  out  WIDTH  direction register (1 drives the pad).
- irq  out  1  registered interrupt request.

Behaviour:
Register map (index: read / write):
- 0: synchronised input (all pins, regardless of direction) / load the out register.
- 1: dir / dir.
- 2: out / out |= wr_data (set).
- 3: out / out &= ~wr_data (clear).
- 4: rise_en / rise_en.
- 5: fall_en / fall_en.
- 6: event / event &= ~wr_data (write-1-to-clear).
- 7: irq_en / irq_en.

Reset (resetq=0 at a clk edge):
- out=OUT_RESET, dir=DIR_RESET.
- rise_en, fall_en, event, irq_en, synchroniser and previous-value register all 0.
- irq=0.
- Writes are ignored while resetq=0.
- Reset mid-operation discards pending events. No edge is reported for the first clock after reset release.

Input path:
- pin_in passes through a SYNC_STAGES-flop chain into s; prev <= s every cycle.
- rise = s & ~prev; fall = ~s & prev.
- Timing for a pad change settled before edge k:
  - s shows the new value after edge k+SYNC_STAGES-1.
  - The event bit sets at edge k+SYNC_STAGES.
  - irq asserts at edge k+SYNC_STAGES+1.
- Glitches shorter than one clock may be missed; this is accepted.

Event update, every cycle:
- event_next = (event & ~clr) | (rise & rise_en) | (fall & fall_en).
- clr = wr_data when a write to index 6 occurs, else 0.
- A new edge in the same cycle as a clear of the same bit sets the bit (set wins).
- Events are sticky until cleared. Disabling rise_en/fall_en does not clear already-captured events.

Interrupt:
- irq <= |(event & irq_en), registered one cycle after event.
- Clearing the last pending enabled event drops irq two edges after the clearing write.

Read/write timing:
- Writes take effect at the clk edge of the write cycle.
- A read in the same cycle as a write returns the pre-write value.
- Reads have no side effects.
- pin_out and pin_oe change the cycle after the write. The top-level SB_IO output register adds one further cycle to the pad.

Decomposition:
- Shared package holds the register-index constants (GPIO_DATA=0 … GPIO_IRQEN=7) and the 16-bit io data width.
- One natural sub-module: gpio_sync, a WIDTH-wide SYNC_STAGES-deep synchroniser with prev-value register. It outputs s, rise and fall.
- Everything else lives in gpio_bank.

Test Plan:
- Reset: hold resetq=0 for 3 cycles with wr=1, index 0, data 0x00FF -> pin_out=0, pin_oe=0, irq=0; all reads return 0x0000.
- Set/clear: write 0x0F to index 0, 0x30 to index 2, then 0x05 to index 3 -> index 2 reads 0x3F then 0x3A; pin_out follows one cycle after each write.
- Edge capture, WIDTH=8, SYNC_STAGES=2: rise_en=0x01, fall_en=0x02, irq_en=0x03.
  - Raise pin 0 before edge k -> event reads 0x01 after edge k+2; irq=1 after edge k+3.
  - Drop pin 1 -> event reads 0x03.
  - Raise pin 1 -> event unchanged.
- W1C race: with event=0x01, write 0x01 to index 6 in the same cycle a new rising edge on pin 0 is detected -> event stays 0x01 and irq stays 1.
- Clear and deassert: write 0x03 to index 6 with no new edges -> event=0x00; irq=0 two edges after the write.
- Width/unselected: WIDTH=4, write 0xFFFF to index 1 -> reads 0x000F. With sel=0, rd_data=0 and writes have no effect.
